// File: rtl/time_display_scan.sv
// Six-digit multiplexed seven-segment scanner for HH.MM.SS.
// Latches a coherent time snapshot once per full scan.
module time_display_scan #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_HOUR_LZ = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(REFRESH_DIV - 1);

  logic [DW-1:0] div_cnt_q;
  logic [2:0]    idx_q;
  logic [5:0]    sec_q;
  logic [5:0]    min_q;
  logic [4:0]    hr_q;
  logic [5:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic [5:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic [5:0]    val;
  logic [3:0]    dig;
  logic          blank;
  logic          tc;

  function automatic logic [6:0] seg_of(
    input logic [3:0] d
  );
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign tc = (div_cnt_q == LAST);

  always_comb begin
    val = '0;
    unique case (idx_q)
      3'd0, 3'd1: val = sec_q;
      3'd2, 3'd3: val = min_q;
      3'd4, 3'd5: val = {1'b0, hr_q};
      default:    val = '0;
    endcase
    // odd digit index selects the tens digit
    if (idx_q[0]) dig = 4'(val / 6'd10);
    else          dig = 4'(val % 6'd10);
    blank = BLANK_HOUR_LZ
         && (idx_q == 3'd5)
         && (dig == 4'd0);
    an_d  = ~(6'b1 << idx_q);
    seg_d = blank ? 7'b1111111 : seg_of(dig);
    dp_d  = ~(((idx_q == 3'd2) || (idx_q == 3'd4))
              && !sec_q[0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      an_q      <= 6'b111111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= tc ? '0 : div_cnt_q + 1'b1;
      if (tc) idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      if ((idx_q == 3'd0) && (div_cnt_q == '0)) begin
        sec_q <= seconds;
        min_q <= minutes;
        hr_q  <= hours;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan.
// Instance a: divider 4 with hour blanking; instance b: divider 1.
module tb_time_display_scan;

  logic       clk;
  logic       rst_a, rst_b;
  logic [5:0] s_a, m_a, s_b, m_b;
  logic [4:0] h_a, h_b;
  logic [5:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  int total = 0;
  int fails = 0;
  int ecnt  = 0;

  time_display_scan #(
    .REFRESH_DIV(4),
    .BLANK_HOUR_LZ(1'b1)
  ) u_a (
    .clk(clk), .rst(rst_a),
    .seconds(s_a), .minutes(m_a), .hours(h_a),
    .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  time_display_scan #(
    .REFRESH_DIV(1),
    .BLANK_HOUR_LZ(1'b0)
  ) u_b (
    .clk(clk), .rst(rst_b),
    .seconds(s_b), .minutes(m_b), .hours(h_b),
    .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segf(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    ecnt++;
  endtask

  task automatic chk(input string tag, input bit b,
                     input logic [5:0] ea,
                     input logic [6:0] es,
                     input logic ed);
    logic [13:0] got, exp;
    got = b ? {an_b, seg_b, dp_b} : {an_a, seg_a, dp_a};
    exp = {ea, es, ed};
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
             tag, ecnt, got[13:8], got[7:1], got[0],
             ea, es, ed);
    end
  endtask

  task automatic exp_scan(input string tag, input bit b,
                          input int dv, input int n,
                          input logic [5:0][3:0] dg,
                          input logic [5:0] dpm,
                          input logic [5:0] blk);
    int i;
    logic [5:0] ea;
    for (int k = 0; k < n; k++) begin
      tick();
      i  = ((ecnt - 1) / dv) % 6;
      ea = ~(6'b1 << i);
      chk(tag, b, ea,
          blk[i] ? 7'b1111111 : segf(dg[i]),
          blk[i] ? 1'b1 : ~dpm[i]);
    end
  endtask

  task automatic reset_a(input logic [5:0] s, m,
                         input logic [4:0] h);
    rst_a = 1'b0;
    s_a = s; m_a = m; h_a = h;
    tick();
    tick();
    rst_a = 1'b1;
    ecnt = 0;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    s_a = 6'd56; m_a = 6'd34; h_a = 5'd12;
    s_b = 6'd56; m_b = 6'd34; h_b = 5'd12;
    tick();
    tick();
    chk("reset_a", 1'b0, 6'b111111, 7'b1111111, 1'b1);
    chk("reset_b", 1'b1, 6'b111111, 7'b1111111, 1'b1);

    // static scan 12:34:56, old zero snapshot on first edge
    rst_a = 1'b1;
    ecnt = 0;
    tick();
    chk("first_edge", 1'b0, 6'b111110, 7'b1000000, 1'b1);
    exp_scan("static", 1'b0, 4, 27,
             {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6},
             6'b010100, 6'b000000);

    // snapshot coherence: 12:34:59 -> 12:35:00 while idx=3
    reset_a(6'd59, 6'd34, 5'd12);
    tick();
    exp_scan("coh_pre", 1'b0, 4, 12,
             {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9},
             6'b000000, 6'b000000);
    s_a = 6'd0; m_a = 6'd35; h_a = 5'd12;
    exp_scan("coh_old", 1'b0, 4, 11,
             {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9},
             6'b000000, 6'b000000);
    tick();
    chk("coh_wrap", 1'b0, 6'b111110, 7'b0010000, 1'b1);
    exp_scan("coh_new", 1'b0, 4, 23,
             {4'd1, 4'd2, 4'd3, 4'd5, 4'd0, 4'd0},
             6'b010100, 6'b000000);

    // leading-zero blanking
    reset_a(6'd0, 6'd0, 5'd7);
    tick();
    exp_scan("blank7", 1'b0, 4, 23,
             {4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0},
             6'b010100, 6'b100000);
    reset_a(6'd0, 6'd0, 5'd17);
    tick();
    exp_scan("hr17", 1'b0, 4, 23,
             {4'd1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0},
             6'b010100, 6'b000000);

    // out-of-range 31:00:63
    reset_a(6'd63, 6'd0, 5'd31);
    tick();
    exp_scan("oor", 1'b0, 4, 23,
             {4'd3, 4'd1, 4'd0, 4'd0, 4'd6, 4'd3},
             6'b000000, 6'b000000);

    // divider 1: rotate every edge, reset mid-scan at idx 4
    rst_b = 1'b1;
    ecnt = 0;
    tick();
    chk("b_first", 1'b1, 6'b111110, 7'b1000000, 1'b1);
    exp_scan("b_rot", 1'b1, 1, 3,
             {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6},
             6'b010100, 6'b000000);
    #2 rst_b = 1'b0;
    #1 chk("b_async", 1'b1, 6'b111111, 7'b1111111, 1'b1);
    tick();
    tick();
    chk("b_hold", 1'b1, 6'b111111, 7'b1111111, 1'b1);
    rst_b = 1'b1;
    ecnt = 0;
    tick();
    chk("b_restart", 1'b1, 6'b111110, 7'b1000000, 1'b1);
    exp_scan("b_resume", 1'b1, 1, 11,
             {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6},
             6'b010100, 6'b000000);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
